au_cnt_gray: RTL and testbench

AU_CNT_GRAY -- requirements
Module: AU_cnt_gray

---
 rtl/au_cnt_gray.sv | 143 ++++++++++++++
 tb/tb_au_cnt_gray.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/au_cnt_gray.sv
// Up/down Gray-code counter with parallel load, terminal count and wrap pulse.
// The next state is formed directly in the Gray domain: the parity of q selects
// whether bit 0 toggles; otherwise the bit just above the lowest set bit toggles.
// ARCH picks how the "all lower bits are zero" prefix is built:
// 0 = ripple chain, 1 = Kogge-Stone log-depth tree, 2 = flat per-bit reduction.
// Any other ARCH value falls back to the ripple chain.
// Optional build macro AU_CNT_GRAY_SAT_EN: saturate at terminal count instead of wrapping.
module au_cnt_gray #(
    parameter int unsigned      WIDTH = 8,
    parameter int unsigned      ARCH  = 0,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bin,
    output logic             tc,
    output logic             wrap
);

    // Gray code of 2^WIDTH-1 is a lone MSB.
    localparam logic [WIDTH-1:0] TcUp = WIDTH'(1) << (WIDTH - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] step;
    logic             wrap_q, wrap_d;

    if (WIDTH == 1) begin : g_w1
        // A 1-bit Gray counter toggles on every step in either direction.
        always_comb step = ~cnt_q;
    end else begin : g_wn
        localparam int PW = int'(WIDTH) - 1;

        // none[i] is set when cnt_q[i-1:0] is all zero (none[0] is vacuously set).
        logic [WIDTH-1:0] none;
        logic [WIDTH-1:0] flip;
        logic             parity;

        if (ARCH == 1) begin : g_ks
            logic [PW-1:0] pre, tmp;
            // Log-depth prefix AND over the inverted lower bits.
            always_comb begin
                pre = ~cnt_q[PW-1:0];
                tmp = '0;
                for (int s = 1; s < PW; s = s * 2) begin
                    tmp = pre;
                    for (int i = s; i < PW; i++) begin
                        pre[i] = tmp[i] & tmp[i-s];
                    end
                end
                none[0] = 1'b1;
                for (int i = 1; i < int'(WIDTH); i++) begin
                    none[i] = pre[i-1];
                end
            end
        end else if (ARCH == 2) begin : g_flat
            logic [WIDTH-1:0] low_mask;
            // Independent wide NOR per output bit.
            always_comb begin
                low_mask = '0;
                for (int i = 0; i < int'(WIDTH); i++) begin
                    low_mask = '0;
                    for (int j = 0; j < i; j++) begin
                        low_mask[j] = 1'b1;
                    end
                    none[i] = ~|(cnt_q & low_mask);
                end
            end
        end else begin : g_ripple
            // Serial prefix AND chain.
            always_comb begin
                none[0] = 1'b1;
                for (int i = 1; i < int'(WIDTH); i++) begin
                    none[i] = none[i-1] & ~cnt_q[i-1];
                end
            end
        end

        assign parity = ^cnt_q;

        // Toggle bit 0 on even parity going up / odd parity going down, otherwise
        // toggle the bit above the lowest set bit; the MSB also absorbs the
        // "no lower bit set" case, which is the wrap step.
        always_comb begin
            flip    = '0;
            flip[0] = parity ^ dir;
            for (int i = 1; i < int'(WIDTH) - 1; i++) begin
                flip[i] = ~flip[0] & cnt_q[i-1] & none[i-1];
            end
            flip[WIDTH-1] = ~flip[0] &
                            (none[WIDTH-1] | (cnt_q[WIDTH-2] & none[WIDTH-2]));
            step = cnt_q ^ flip;
        end
    end

    // Terminal count tracks dir combinationally.
    assign tc = dir ? (cnt_q == TcUp) : (cnt_q == '0);

    // Next-state selection: load beats count, count beats hold.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d = d;
        end else if (en) begin
`ifdef AU_CNT_GRAY_SAT_EN
            if (!tc) begin
                cnt_d = step;
            end
`else
            cnt_d  = step;
            wrap_d = tc;
`endif
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= INIT;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    // Gray to binary: running XOR from the MSB down.
    always_comb begin
        q_bin[WIDTH-1] = cnt_q[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            q_bin[i] = q_bin[i+1] ^ cnt_q[i];
        end
    end

    assign q    = cnt_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_au_cnt_gray.sv
// Self-checking bench for au_cnt_gray: four instances (W4/ARCH0, W4/ARCH1 with
// INIT=1100, W1, W8/ARCH2) share stimulus; a binary reference model feeds a
// scoreboard that is checked after every clock edge.
module tb_au_cnt_gray;

    typedef struct packed {
        logic [15:0] bin;
        logic        wrap;
    } mst_t;

    typedef struct packed {
        mst_t a;
        mst_t b;
        mst_t c;
        mst_t d;
        logic dir;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, en, dir, load;
    logic [7:0] d;

    logic [3:0] qa, qba, qb, qbb;
    logic [0:0] qc, qbc;
    logic [7:0] qd, qbd;
    logic       tca, tcb, tcc, tcd;
    logic       wra, wrb, wrc, wrd;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    mst_t ma, mb, mc, md;
    logic sat;

    always #5 clk = ~clk;

    au_cnt_gray #(.WIDTH(4), .ARCH(0), .INIT(4'b0000)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .d(d[3:0]),
        .q(qa), .q_bin(qba), .tc(tca), .wrap(wra)
    );
    au_cnt_gray #(.WIDTH(4), .ARCH(1), .INIT(4'b1100)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .d(d[3:0]),
        .q(qb), .q_bin(qbb), .tc(tcb), .wrap(wrb)
    );
    au_cnt_gray #(.WIDTH(1), .ARCH(0), .INIT(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .d(d[0:0]),
        .q(qc), .q_bin(qbc), .tc(tcc), .wrap(wrc)
    );
    au_cnt_gray #(.WIDTH(8), .ARCH(2), .INIT(8'h00)) u_d (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .d(d),
        .q(qd), .q_bin(qbd), .tc(tcd), .wrap(wrd)
    );

    function automatic logic [15:0] g2b(input logic [15:0] g);
        logic [15:0] b;
        b = g;
        for (int s = 1; s < 16; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [15:0] b2g(input logic [15:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [15:0] mask_of(input int w);
        return 16'((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic tc_of(input int w, input logic [15:0] b, input logic dr);
        return dr ? (b == mask_of(w)) : (b == 16'h0);
    endfunction

    // Binary reference: +/-1 modulo 2^w, wrap flagged when stepping from terminal.
    function automatic mst_t model_step(input int w, input mst_t s, input logic r,
                                        input logic e, input logic dr, input logic ld,
                                        input logic [15:0] dg, input logic [15:0] ig);
        mst_t n;
        logic t;
        n      = s;
        n.wrap = 1'b0;
        if (!r) begin
            n.bin = g2b(ig & mask_of(w));
        end else if (ld) begin
            n.bin = g2b(dg & mask_of(w));
        end else if (e) begin
            t = tc_of(w, s.bin, dr);
            if (!(sat && t)) begin
                n.bin  = (dr ? s.bin + 16'd1 : s.bin - 16'd1) & mask_of(w);
                n.wrap = t & ~sat;
            end
        end
        return n;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle at the falling edge, predict, then check after the rising edge.
    task automatic cycle(input logic r, input logic e, input logic dr, input logic ld,
                         input logic [7:0] dv);
        exp_t       x;
        mst_t       olda;
        logic [3:0] prev;
        @(negedge clk);
        rst_n = r;
        en    = e;
        dir   = dr;
        load  = ld;
        d     = dv;
        prev  = qa;
        olda  = ma;
        ma    = model_step(4, ma, r, e, dr, ld, {8'h0, dv}, 16'h0000);
        mb    = model_step(4, mb, r, e, dr, ld, {8'h0, dv}, 16'h000C);
        mc    = model_step(1, mc, r, e, dr, ld, {8'h0, dv}, 16'h0000);
        md    = model_step(8, md, r, e, dr, ld, {8'h0, dv}, 16'h0000);
        x.a   = ma;
        x.b   = mb;
        x.c   = mc;
        x.d   = md;
        x.dir = dr;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        check_eq("sb_depth", sb_q.size(), 1);
        if (sb_q.size() != 0) begin
            x = sb_q.pop_front();
            check_eq("a_q", qa, b2g(x.a.bin));
            check_eq("a_qbin", qba, x.a.bin);
            check_eq("a_wrap", wra, x.a.wrap);
            check_eq("a_tc", tca, tc_of(4, x.a.bin, x.dir));
            check_eq("b_q", qb, b2g(x.b.bin));
            check_eq("b_qbin", qbb, x.b.bin);
            check_eq("b_wrap", wrb, x.b.wrap);
            check_eq("b_tc", tcb, tc_of(4, x.b.bin, x.dir));
            check_eq("c_q", qc, b2g(x.c.bin));
            check_eq("c_qbin", qbc, x.c.bin);
            check_eq("c_wrap", wrc, x.c.wrap);
            check_eq("c_tc", tcc, tc_of(1, x.c.bin, x.dir));
            check_eq("d_q", qd, b2g(x.d.bin));
            check_eq("d_qbin", qbd, x.d.bin);
            check_eq("d_wrap", wrd, x.d.wrap);
            check_eq("d_tc", tcd, tc_of(8, x.d.bin, x.dir));
            if (r && !ld && e && (olda.bin != x.a.bin)) begin
                check_eq("a_onebit", $countones(qa ^ prev), 1);
            end
        end
    endtask

    logic [3:0] up_seq [16];

    initial begin
        logic       r, e, dr, ld;
        logic [7:0] dv;
`ifdef AU_CNT_GRAY_SAT_EN
        sat = 1'b1;
`else
        sat = 1'b0;
`endif
        up_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                   4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        rst_n = 1'b0;
        en    = 1'b0;
        dir   = 1'b0;
        load  = 1'b0;
        d     = '0;
        ma    = '0;
        mb    = '0;
        mc    = '0;
        md    = '0;

        // Reset ignores en/load/d.
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h5A);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("rst_a_q", qa, 4'b0000);
        check_eq("rst_b_q", qb, 4'b1100);
        check_eq("rst_a_wrap", wra, 1'b0);

        // Full up cycle through the wrap.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
            check_eq("up_seq", qa, (sat && i == 15) ? 4'b1000 : up_seq[i]);
        end
        check_eq("up_wrap", wra, sat ? 1'b0 : 1'b1);

        // Load then count down.
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h06);
        check_eq("ld_q", qa, 4'b0110);
        check_eq("ld_qbin", qba, 4'b0100);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("dn_q", qa, 4'b0010);
        check_eq("dn_qbin", qba, 4'b0011);

        // Down from zero: tc follows dir immediately, then wrap or saturate.
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        dir = 1'b0;
        #1;
        check_eq("tc_dir_dn", tca, 1'b1);
        dir = 1'b1;
        #1;
        check_eq("tc_dir_up", tca, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("dn_wrap_q", qa, sat ? 4'b0000 : 4'b1000);
        check_eq("dn_wrap", wra, sat ? 1'b0 : 1'b1);

        // Load wins over en even at terminal count.
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h08);
        check_eq("tc_at_1000", tca, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 8'h0A);
        check_eq("ld_en_q", qa, 4'b1010);
        check_eq("ld_en_wrap", wra, 1'b0);

        // Reset mid-count, then resume from INIT.
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'h05);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        check_eq("mid_rst_a", qa, 4'b0000);
        check_eq("mid_rst_b", qb, 4'b1100);
        check_eq("mid_rst_wrap", wra, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
        check_eq("resume_a", qa, 4'b0001);
        check_eq("resume_b", qb, 4'b1101);

        // Random traffic, with load values biased toward the terminal codes.
        for (int n = 0; n < 4000; n++) begin
            r  = ($urandom_range(63) != 0);
            ld = ($urandom_range(7) == 0);
            e  = ($urandom_range(3) != 0);
            dr = 1'($urandom_range(1));
            case ($urandom_range(3))
                0:       dv = 8'h80;
                1:       dv = 8'h00;
                default: dv = 8'($urandom);
            endcase
            cycle(r, e, dr, ld, dv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
